sensor_responder: RTL and testbench

Sensor-side end of the polled UART sensor bus. Decodes poll bytes from the UART receiver and, when a poll carries this node's sensor number, returns a two-byte response through the UART transmitter: the latest sensor sample, then its CRC-8. The response is exactly what the bus arbiter consumes as `{sensor, data, crc}`. Sits between a local sensor front-end and one UART RX/TX core pair.

---
 rtl/sensor_bus_pkg.sv | 31 +++
 rtl/sensor_responder_if.sv | 20 ++
 rtl/crc8.sv | 15 +
 rtl/sensor_responder.sv | 153 +++++++++++++++
 tb/tb_sensor_responder.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_bus_pkg.sv
// Shared definitions for the polled UART sensor bus: responder state
// encoding, poll byte field widths, collision code and the CRC-8 helper.
package sensor_bus_pkg;

    localparam int POLL_ID_W  = 3;
    localparam int POLL_RSV_W = 5;

    localparam logic [7:0]           CRC8_POLY    = 8'h07;
    localparam logic [POLL_ID_W-1:0] COLLISION_ID = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_SEND_DATA,
        ST_WAIT_DATA,
        ST_SEND_CRC,
        ST_WAIT_CRC
    } resp_state_e;

    // CRC-8 of a single byte: init 0, MSB first, no reflection, no final XOR.
    // With a zero init the byte itself is the initial remainder.
    function automatic logic [7:0] crc8_byte(input logic [7:0] data);
        logic [7:0] rem;
        rem = data;
        for (int i = 0; i < 8; i++) begin
            rem = rem[7] ? ({rem[6:0], 1'b0} ^ CRC8_POLY) : {rem[6:0], 1'b0};
        end
        return rem;
    endfunction

endpackage

// File: rtl/sensor_responder_if.sv
// UART core pair as seen by the sensor responder. The master modport is the
// responder side; the slave modport is the RX/TX cores (or a model of them).
interface sensor_responder_if;
    logic       done_rx;
    logic [7:0] data_rx;
    logic       enable_tx;
    logic [7:0] data_tx;
    logic       active_tx;
    logic       done_tx;

    modport master (
        input  done_rx, data_rx, active_tx, done_tx,
        output enable_tx, data_tx
    );

    modport slave (
        output done_rx, data_rx, active_tx, done_tx,
        input  enable_tx, data_tx
    );
endinterface

// File: rtl/crc8.sv
// Combinational CRC-8 (poly 0x07) over one byte; shared with the arbiter's
// response check.
module crc8
    import sensor_bus_pkg::*;
(
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    // Pure function of the input byte.
    always_comb begin
        crc_out = crc8_byte(data_in);
    end

endmodule

// File: rtl/sensor_responder.sv
// Sensor-side responder: answers polls carrying SENSOR_ID with the frozen
// sample byte followed by its CRC-8.
// Optional macro SENSOR_RESPONDER_TURNAROUND_EN inserts a TURNAROUND_CYCLES
// idle gap between the poll and the first response byte.
module sensor_responder
    import sensor_bus_pkg::*;
#(
    parameter logic [POLL_ID_W-1:0] SENSOR_ID         = 3'd1,
    parameter int                   TX_TIMEOUT        = 65535,
    parameter int                   TURNAROUND_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          sensor_data,
    input  logic                sensor_valid,
    sensor_responder_if.master  uart,
    output logic                busy,
    output logic                tx_error
);

    localparam int CW = $clog2(TX_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TX_TIMEOUT - 1);

    resp_state_e state_q, state_d;
    logic [7:0]    sample_q;
    logic [7:0]    resp_q, resp_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          tx_error_q, tx_error_d;
    logic [7:0]    crc;
    logic          poll_ok;

    // done_tx alone ends a wait and the counter bounds it, so the busy flag
    // of the transmitter carries no extra information here.
    logic unused_active_tx;
    assign unused_active_tx = uart.active_tx;

`ifdef SENSOR_RESPONDER_TURNAROUND_EN
    localparam int TW = $clog2(TURNAROUND_CYCLES + 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND_CYCLES - 1);
    logic [TW-1:0] turn_cnt_q, turn_cnt_d;
`endif

    crc8 u_crc8 (
        .data_in (resp_q),
        .crc_out (crc)
    );

    assign poll_ok = uart.done_rx
                  && (uart.data_rx[POLL_ID_W-1:0] == SENSOR_ID)
                  && (uart.data_rx[7:POLL_ID_W] == '0);

    // State, counters, sample and snapshot registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sample_q   <= 8'h00;
            resp_q     <= 8'h00;
            wait_cnt_q <= '0;
            tx_error_q <= 1'b0;
`ifdef SENSOR_RESPONDER_TURNAROUND_EN
            turn_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            resp_q     <= resp_d;
            wait_cnt_q <= wait_cnt_d;
            tx_error_q <= tx_error_d;
`ifdef SENSOR_RESPONDER_TURNAROUND_EN
            turn_cnt_q <= turn_cnt_d;
`endif
            if (sensor_valid) begin
                sample_q <= sensor_data;
            end
        end
    end

    // Next-state and Moore outputs; the snapshot reads sample_q before any
    // same-cycle sensor update lands.
    always_comb begin
        state_d        = state_q;
        resp_d         = resp_q;
        wait_cnt_d     = wait_cnt_q;
        tx_error_d     = tx_error_q;
        uart.enable_tx = 1'b0;
        uart.data_tx   = 8'h00;
`ifdef SENSOR_RESPONDER_TURNAROUND_EN
        turn_cnt_d     = turn_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (poll_ok) begin
                    resp_d = sample_q;
`ifdef SENSOR_RESPONDER_TURNAROUND_EN
                    turn_cnt_d = '0;
                    state_d    = ST_TURN;
`else
                    state_d    = ST_SEND_DATA;
`endif
                end
            end
`ifdef SENSOR_RESPONDER_TURNAROUND_EN
            ST_TURN: begin
                if (turn_cnt_q == TURN_LAST) begin
                    state_d = ST_SEND_DATA;
                end else begin
                    turn_cnt_d = turn_cnt_q + TW'(1);
                end
            end
`endif
            ST_SEND_DATA: begin
                uart.enable_tx = 1'b1;
                uart.data_tx   = resp_q;
                wait_cnt_d     = '0;
                state_d        = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                uart.data_tx = resp_q;
                if (uart.done_tx) begin
                    state_d = ST_SEND_CRC;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ST_IDLE;
                    tx_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            ST_SEND_CRC: begin
                uart.enable_tx = 1'b1;
                uart.data_tx   = crc;
                wait_cnt_d     = '0;
                state_d        = ST_WAIT_CRC;
            end
            ST_WAIT_CRC: begin
                uart.data_tx = crc;
                if (uart.done_tx) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ST_IDLE;
                    tx_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign tx_error = tx_error_q;

endmodule

// File: tb/tb_sensor_responder.sv
// Bench for sensor_responder: directed scenarios plus a randomized phase,
// all checked every cycle against a transaction-level model of the response.
module tb_sensor_responder;

    localparam logic [2:0] SID     = 3'd3;
    localparam int         TIMEOUT = 20;
    localparam int         TURNCYC = 4;
`ifdef SENSOR_RESPONDER_TURNAROUND_EN
    localparam int GAP = TURNCYC;
`else
    localparam int GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sensor_data = 8'h00;
    logic       sensor_valid = 1'b0;
    logic       busy, tx_error;

    sensor_responder_if u ();

    sensor_responder #(
        .SENSOR_ID         (SID),
        .TX_TIMEOUT        (TIMEOUT),
        .TURNAROUND_CYCLES (TURNCYC)
    ) dut (
        .clock        (clk),
        .reset        (reset),
        .sensor_data  (sensor_data),
        .sensor_valid (sensor_valid),
        .uart         (u.master),
        .busy         (busy),
        .tx_error     (tx_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [7:0] sent_log[$];
    bit withhold_all = 0;
    bit rand_drop = 0;
    int lat_fixed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [7:0] ref_crc(input logic [7:0] b);
        // Long division of b*x^8 by x^8+x^2+x+1, bit by bit.
        logic [15:0] r;
        r = {b, 8'h00};
        for (int i = 15; i >= 8; i--)
            if (r[i]) r = r ^ (16'h0107 << (i - 8));
        return r[7:0];
    endfunction

    // UART core model: answers each enable_tx with done_tx after a latency,
    // unless that byte is withheld.
    initial begin
        int  left;
        bit  pending, drop_cur;
        pending = 0; left = 0; drop_cur = 0;
        u.done_tx = 1'b0;
        u.active_tx = 1'b0;
        forever begin
            @(posedge clk); #1;
            u.done_tx = 1'b0;
            if (!busy) pending = 0;
            if (pending) begin
                left--;
                if (left == 0) begin
                    pending = 0;
                    if (!drop_cur) u.done_tx = 1'b1;
                end
            end
            if (u.enable_tx) begin
                pending = 1;
                left = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 5);
                drop_cur = withhold_all || (rand_drop && ($urandom_range(0, 19) == 0));
            end
            u.active_tx = pending;
        end
    end

    // Reference model and per-cycle compare, evaluated mid-cycle.
    initial begin
        int         cyc, next_en, sent, wait_len;
        bit         in_resp, waiting, m_err, exp_en;
        logic [7:0] sample, resp, exp_byte;
        cyc = 0; next_en = -1; sent = 0; wait_len = 0;
        in_resp = 0; waiting = 0; m_err = 0; sample = 8'h00; resp = 8'h00;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            exp_en   = in_resp && !waiting && (cyc == next_en);
            exp_byte = (sent == 0) ? resp : ref_crc(resp);
            chk("enable_tx", u.enable_tx, exp_en);
            chk("busy", busy, in_resp);
            chk("tx_error", tx_error, m_err);
            if (exp_en || waiting) chk("data_tx", u.data_tx, exp_byte);
            if (u.enable_tx) sent_log.push_back(u.data_tx);
            if (reset) begin
                in_resp = 0; waiting = 0; m_err = 0; sample = 8'h00;
            end else begin
                if (!in_resp) begin
                    if (u.done_rx && u.data_rx == {5'b0, SID}) begin
                        in_resp = 1; resp = sample; sent = 0; waiting = 0;
                        next_en = cyc + 1 + GAP;
                    end
                end else if (!waiting) begin
                    if (cyc == next_en) begin
                        waiting = 1; wait_len = 0;
                    end
                end else if (u.done_tx) begin
                    sent++;
                    waiting = 0;
                    if (sent == 2) in_resp = 0;
                    else next_en = cyc + 1;
                end else begin
                    wait_len++;
                    if (wait_len == TIMEOUT) begin
                        in_resp = 0; waiting = 0; m_err = 1;
                    end
                end
                if (sensor_valid) sample = sensor_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        reset = 1'b0;
        u.done_rx = 1'b0;
        sensor_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        tick();
        while (busy && n < 300) begin tick(); n++; end
        checks++;
        if (n >= 300) $display("FAIL %s: busy still %0b after %0d cycles, required 0", name, busy, n);
        else passes++;
        tick();
    endtask

    task automatic poll(input logic [7:0] b);
        u.done_rx = 1'b1;
        u.data_rx = b;
    endtask

    task automatic expect_log(input string name, input int n, input logic [7:0] b0, input logic [7:0] b1);
        chk({name, " count"}, sent_log.size(), n);
        if (n >= 1 && sent_log.size() >= 1) chk({name, " byte0"}, sent_log[0], b0);
        if (n >= 2 && sent_log.size() >= 2) chk({name, " byte1"}, sent_log[1], b1);
    endtask

    initial begin
        int n;
        u.done_rx = 1'b0;
        u.data_rx = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset data_tx", u.data_tx, 8'h00);
        chk("reset enable_tx", u.enable_tx, 1'b0);
        tick();

        // Basic response: sample 0x01 -> 0x01, CRC 0x07.
        sensor_valid = 1'b1; sensor_data = 8'h01;
        tick();
        sent_log.delete();
        poll(8'h03);
        tick();
        chk("busy after poll", busy, 1'b1);
        wait_idle("basic idle");
        expect_log("basic", 2, 8'h01, 8'h07);
        $display("txn basic: sent %0d bytes", sent_log.size());

        // Foreign IDs and nonzero reserved bits are ignored.
        sent_log.delete();
        poll(8'h05); tick();
        poll(8'h0B); tick();
        repeat (5) tick();
        expect_log("ignored", 0, 8'h00, 8'h00);
        chk("ignored busy", busy, 1'b0);
        $display("txn ignored polls 05/0B");

        // Same-cycle sensor update does not disturb the snapshot.
        sent_log.delete();
        poll(8'h03); sensor_valid = 1'b1; sensor_data = 8'h02;
        wait_idle("snap idle");
        expect_log("snapshot", 2, 8'h01, 8'h07);
        $display("txn snapshot old sample");
        sent_log.delete();
        poll(8'h03);
        wait_idle("snap2 idle");
        expect_log("snapshot next", 2, 8'h02, 8'h0E);
        $display("txn snapshot new sample");

        // Poll echo arriving mid-response is ignored.
        lat_fixed = 4;
        sent_log.delete();
        poll(8'h03); tick(); tick();
        poll(8'h03);
        wait_idle("echo idle");
        repeat (4) tick();
        expect_log("echo", 2, 8'h02, 8'h0E);
        $display("txn echo ignored");

        // Transmit timeout sets the sticky error; service continues.
        withhold_all = 1;
        sent_log.delete();
        poll(8'h03);
        wait_idle("timeout idle");
        chk("timeout tx_error", tx_error, 1'b1);
        expect_log("timeout", 1, 8'h02, 8'h00);
        withhold_all = 0;
        sent_log.delete();
        poll(8'h03);
        wait_idle("after timeout idle");
        expect_log("after timeout", 2, 8'h02, 8'h0E);
        chk("sticky tx_error", tx_error, 1'b1);
        $display("txn timeout");

        // Reset while waiting for the CRC byte abandons the frame.
        sent_log.delete();
        poll(8'h03);
        n = 0;
        tick();
        while (sent_log.size() < 2 && n < 100) begin tick(); n++; end
        chk("reach wait_crc", (n < 100), 1'b1);
        reset = 1'b1;
        tick();
        chk("reset mid busy", busy, 1'b0);
        repeat (10) tick();
        expect_log("reset mid", 2, 8'h02, 8'h0E);
        chk("reset mid tx_error", tx_error, 1'b0);
        $display("txn reset mid-response");

        // Randomized traffic checked by the model every cycle.
        lat_fixed = 0;
        rand_drop = 1;
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 20) poll(8'h03);
            else if (r < 30) poll(8'($urandom_range(0, 255)));
            else if (r < 34) poll({5'($urandom_range(1, 31)), SID});
            if ($urandom_range(0, 3) == 0) begin
                sensor_valid = 1'b1;
                sensor_data = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            tick();
        end
        rand_drop = 0;
        wait_idle("final idle");
        $display("txn random phase done");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
